// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if -- request/response bundle between the EX stage and the
// iterative multiply/divide unit.
//   master (EX stage) drives: flush, start, funct3, rs1_data, rs2_data, rd_in
//   slave  (ex_muldiv) drives: busy, stall, done, result, rd_out
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output flush, start, funct3, rs1_data, rs2_data, rd_in,
    input  busy, stall, done, result, rd_out
  );

  modport slave (
    input  flush, start, funct3, rs1_data, rs2_data, rd_in,
    output busy, stall, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide unit for the EX stage.
// One bit per cycle: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied when the result is written.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   mdu  - ex_muldiv_if.slave: flush/start/funct3/rs1_data/rs2_data/rd_in in,
//          busy/stall/done/result/rd_out out
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_if.slave  mdu
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [5:0]        cnt_r;
  logic [2*XLEN-1:0] acc_r;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_r;       // multiplicand / divisor magnitude
  logic [2:0]        funct3_r;
  logic              is_div_r;
  logic              neg_res_r;   // product / quotient must be negated
  logic              neg_rem_r;   // remainder follows the dividend sign
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   result_r;
  logic [4:0]        rd_out_r;
  logic              done_r;
  logic              busy_r;

  logic              accept_s;
  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic              is_div_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              bypass_s;
  logic [XLEN-1:0]   bypass_val_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN:0]   div_shl_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_s;

  assign accept_s = (state_r == IDLE) & mdu.start & ~mdu.flush;

  // Operand classification and magnitudes for the op being offered.
  always_comb begin
    a_signed_s = (mdu.funct3 == 3'd1) | (mdu.funct3 == 3'd2) |
                 (mdu.funct3 == 3'd4) | (mdu.funct3 == 3'd6);
    b_signed_s = (mdu.funct3 == 3'd1) | (mdu.funct3 == 3'd4) | (mdu.funct3 == 3'd6);
    a_neg_s    = a_signed_s & mdu.rs1_data[XLEN-1];
    b_neg_s    = b_signed_s & mdu.rs2_data[XLEN-1];
    if (a_neg_s) begin
      a_mag_s = 32'd0 - mdu.rs1_data;
    end else begin
      a_mag_s = mdu.rs1_data;
    end
    if (b_neg_s) begin
      b_mag_s = 32'd0 - mdu.rs2_data;
    end else begin
      b_mag_s = mdu.rs2_data;
    end
    is_div_s   = mdu.funct3[2];
    div_zero_s = is_div_s & (mdu.rs2_data == 32'd0);
    div_ovf_s  = is_div_s & ~mdu.funct3[0] &
                 (mdu.rs1_data == 32'h8000_0000) & (mdu.rs2_data == 32'hFFFF_FFFF);
    bypass_s   = div_zero_s | div_ovf_s;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero_s) begin
      bypass_val_s = mdu.funct3[1] ? mdu.rs1_data : 32'hFFFF_FFFF;
    end else begin
      bypass_val_s = mdu.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step of either the multiplier or the divider.
  always_comb begin
    // multiply: conditionally add multiplicand into the high half, shift right
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    // divide: shift left, trial-subtract divisor, keep it only if non-negative
    div_shl_s  = {acc_r, 1'b0};
    div_diff_s = div_shl_s[2*XLEN:XLEN] - {1'b0, opb_r};
    if (is_div_r) begin
      if (div_diff_s[XLEN]) begin
        acc_nxt_s = div_shl_s[2*XLEN-1:0];
      end else begin
        acc_nxt_s = {div_diff_s[XLEN-1:0], div_shl_s[XLEN-1:1], 1'b1};
      end
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection from the final accumulator value.
  always_comb begin
    prod_s = neg_res_r ? (64'd0 - acc_nxt_s) : acc_nxt_s;
    quot_s = neg_res_r ? (32'd0 - acc_nxt_s[XLEN-1:0]) : acc_nxt_s[XLEN-1:0];
    rem_s  = neg_rem_r ? (32'd0 - acc_nxt_s[2*XLEN-1:XLEN]) : acc_nxt_s[2*XLEN-1:XLEN];
    case (funct3_r)
      3'd0:                   final_s = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:       final_s = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:             final_s = quot_s;
      3'd6, 3'd7:             final_s = rem_s;
      default:                final_s = 32'd0;
    endcase
  end

  // Next-state decode; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = bypass_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (mdu.flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == 6'd31) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      acc_r     <= 64'd0;
      opb_r     <= 32'd0;
      funct3_r  <= 3'd0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      rd_r      <= 5'd0;
      result_r  <= 32'd0;
      rd_out_r  <= 5'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            funct3_r  <= mdu.funct3;
            rd_r      <= mdu.rd_in;
            is_div_r  <= is_div_s;
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            opb_r     <= b_mag_s;
            acc_r     <= {32'd0, a_mag_s};
            cnt_r     <= 6'd0;
            if (bypass_s) begin
              result_r <= bypass_val_s;
              rd_out_r <= mdu.rd_in;
            end
          end
        end
        CALC: begin
          if (mdu.flush) begin
            cnt_r <= 6'd0;
          end else if (cnt_r == 6'd31) begin
            acc_r    <= acc_nxt_s;
            cnt_r    <= 6'd0;
            result_r <= final_s;
            rd_out_r <= rd_r;
          end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          cnt_r <= 6'd0;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

  // stall must react in the accept cycle itself, so it is decoded from
  // registered state plus the live request; reset holds it low.
  assign mdu.stall  = ~rst & (accept_s | (state_r == CALC));
  assign mdu.busy   = busy_r;
  assign mdu.done   = done_r;
  assign mdu.result = result_r;
  assign mdu.rd_out = rd_out_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv -- directed, table-driven bench for ex_muldiv, plus hand
// sequences for flush, start+flush collision and mid-operation reset.
module tb_ex_muldiv;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_muldiv_if ifc ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .mdu (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    int stalls;
    bit seen;
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.funct3   = v.f3;
    ifc.rs1_data = v.a;
    ifc.rs2_data = v.b;
    ifc.rd_in    = v.rd;
    #1;
    stalls = ifc.stall ? 1 : 0;
    @(negedge clk);
    // operands must already be latched; scramble the bus
    ifc.start    = 1'b0;
    ifc.rs1_data = 32'hDEAD_BEEF;
    ifc.rs2_data = 32'h1234_5678;
    ifc.rd_in    = 5'd31;
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (ifc.done) begin
        seen = 1'b1;
      end else begin
        if (ifc.stall) stalls++;
        n++;
        @(negedge clk);
      end
    end
    check($sformatf("v%0d_latency", idx), seen ? n : 32'hFFFF_FFFF, v.lat);
    check($sformatf("v%0d_result", idx), ifc.result, v.exp);
    check($sformatf("v%0d_rd_out", idx), {27'd0, ifc.rd_out}, {27'd0, v.rd});
    check($sformatf("v%0d_stall_cycles", idx), stalls, (v.lat == 1) ? 1 : 33);
    check($sformatf("v%0d_busy_in_done", idx), {31'd0, ifc.busy}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_done_single", idx), {31'd0, ifc.done}, 32'd0);
  endtask

  initial begin
    int n;
    bit saw_done;
    checks = 0;
    errors = 0;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd5, 32'd100,       32'd0,         5'd4,  32'hFFFF_FFFF, 1};
    vecs[5]  = '{3'd7, 32'd100,       32'd0,         5'd6,  32'd100,       1};
    vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1};
    vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'd0,         1};
    vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33};
    vecs[9]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33};
    vecs[10] = '{3'd5, 32'd9,         32'd2,         5'd11, 32'd4,         33};
    vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 33};
    vecs[12] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'd1,         33};
    vecs[13] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33};
    vecs[14] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd1,         33};
    vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'd0,         33};
    vecs[16] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 33};
    vecs[17] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9, 1};

    // reset state, with a request held on the bus to prove stall is gated
    rst          = 1'b1;
    ifc.flush    = 1'b0;
    ifc.start    = 1'b1;
    ifc.funct3   = 3'd0;
    ifc.rs1_data = 32'd3;
    ifc.rs2_data = 32'd3;
    ifc.rd_in    = 5'd1;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, ifc.busy},   32'd0);
    check("reset_stall",  {31'd0, ifc.stall},  32'd0);
    check("reset_done",   {31'd0, ifc.done},   32'd0);
    check("reset_result", ifc.result,          32'd0);
    check("reset_rd_out", {27'd0, ifc.rd_out}, 32'd0);
    ifc.start = 1'b0;
    rst       = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i], i);
    end

    // flush after 10 CALC cycles: no done, outputs keep the last result
    @(negedge clk);
    ifc.start    = 1'b1;
    ifc.funct3   = 3'd0;
    ifc.rs1_data = 32'd3;
    ifc.rs2_data = 32'd5;
    ifc.rd_in    = 5'd9;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {31'd0, ifc.busy}, 32'd1);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    check("flush_busy_after", {31'd0, ifc.busy}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ifc.done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_result_held", ifc.result, vecs[17].exp);
    check("flush_rd_held", {27'd0, ifc.rd_out}, {27'd0, vecs[17].rd});

    // start together with flush in IDLE is not accepted
    ifc.start    = 1'b1;
    ifc.flush    = 1'b1;
    ifc.funct3   = 3'd5;
    ifc.rs1_data = 32'd8;
    ifc.rs2_data = 32'd0;
    ifc.rd_in    = 5'd20;
    #1;
    check("collide_stall", {31'd0, ifc.stall}, 32'd0);
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    check("collide_busy", {31'd0, ifc.busy}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (ifc.done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("collide_no_done", {31'd0, saw_done}, 32'd0);

    // rst pulsed at CALC cycle 20 clears everything at once
    ifc.start    = 1'b1;
    ifc.funct3   = 3'd3;
    ifc.rs1_data = 32'hFFFF_0000;
    ifc.rs2_data = 32'h0001_0000;
    ifc.rd_in    = 5'd21;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_busy_before", {31'd0, ifc.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy",   {31'd0, ifc.busy},   32'd0);
    check("rst_stall",  {31'd0, ifc.stall},  32'd0);
    check("rst_done",   {31'd0, ifc.done},   32'd0);
    check("rst_result", ifc.result,          32'd0);
    check("rst_rd_out", {27'd0, ifc.rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    n = 0;
    while (n < 20) begin
      if (ifc.done) saw_done = 1'b1;
      n++;
      @(negedge clk);
    end
    check("rst_no_done", {31'd0, saw_done}, 32'd0);
    run_op('{3'd5, 32'd9, 32'd2, 5'd3, 32'd4, 33}, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  abort any in-flight operation (branch/jump redirect from EX).
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 rs1_data  input  32  operand A / dividend, from ID/EX register outputs.
REQ-008 rs2_data  input  32  operand B / divisor, from ID/EX register outputs.
REQ-009 rd_in  input  5  destination register tag.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 stall  output  1  freezes PC, IF/ID and ID/EX while an op is accepted or computing.
REQ-012 done  output  1  one-cycle pulse; result and rd_out are valid in that cycle.
REQ-013 result  output  32  operation result.
REQ-014 rd_out  output  5  destination tag captured at accept.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 Accept: in IDLE with start=1 and flush=0, the block latches funct3, operands and rd_in; start at any other time SHALL be ignored.
REQ-017 Normal path: IDLE->CALC, exactly 32 CALC cycles (one bit per cycle, 6-bit counter), ->DONE, ->IDLE; done is high 33 cycles after the accept edge.
REQ-018 Multiply: radix-2 shift-add on operand magnitudes; 64-bit product negated when signs differ; MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
REQ-019 Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU, DIVU and REMU treat both as unsigned; DIV and REM treat both as signed.
REQ-020 Divide: restoring division on magnitudes; quotient negated when signs differ; remainder takes the sign of the dividend.
REQ-021 Divide by zero SHALL bypass CALC (IDLE->DONE, done one cycle after accept): DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
REQ-022 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) SHALL bypass CALC: DIV returns 0x80000000, REM returns 0.
REQ-023 stall = (IDLE & start & ~flush) | CALC; stall is low in DONE so the pipeline advances with the result.
REQ-024 busy is high in CALC and DONE.
REQ-025 flush in CALC or DONE SHALL force IDLE at the next edge with no done pulse; flush wins over a simultaneous start in IDLE.
REQ-026 result and rd_out SHALL hold their last values until the next done; the internal accumulator is not visible.
REQ-027 done is never asserted in two consecutive cycles.

Reset
REQ-028 While rst is high: state=IDLE, counter=0, busy=0, stall=0, done=0, result=0, rd_out=0, all internal operand registers cleared.
REQ-029 Assertion of rst mid-operation SHALL abandon the operation immediately with no done pulse; the first start after deassertion is accepted normally.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD, rd=5 -> done 33 cycles after accept, result=0xFFFFFFEB, rd_out=5, stall high for 33 cycles.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> done 1 cycle after accept, result=0xFFFFFFFF; REMU 100 / 0 -> 100.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle; REM -7 / 2 -> 0xFFFFFFFF; DIV -7 / 2 -> 0xFFFFFFFD.
REQ-034 Flush at CALC cycle 10 -> IDLE next edge, no done, result unchanged; start+flush together in IDLE -> not accepted.
REQ-035 rst pulsed at CALC cycle 20 -> all outputs 0 immediately; a subsequent DIVU 9/2 -> result 4 after 33 cycles.
